apb_xip_cache: RTL

Direct-mapped, word-granular read cache on APB, directly upstream of the SPI/XIP APB slave. It serves CPU reads in the flash XIP window from local storage and forwards misses, writes and non-flash accesses one-for-one to the SPI slave. A hit completes with zero wait states, removing the ~150-cycle SPI transaction from repeated instruction fetches.

---
 rtl/xip_cache_pkg.sv | 36 +++
 rtl/xip_cache_store.sv | 49 ++++
 rtl/apb_xip_cache.sv | 125 ++++++++++++
 3 files changed

// File: rtl/xip_cache_pkg.sv
// Shared types, widths and flash-window helpers for the XIP read cache.
package xip_cache_pkg;

  localparam logic [31:0] FLASH_START = 32'h3000_0000;
  localparam logic [31:0] FLASH_END   = 32'h3fff_ffff;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_HIT        = 3'd1;
  localparam state_t ST_FWD_SETUP  = 3'd2;
  localparam state_t ST_FWD_ACCESS = 3'd3;
  localparam state_t ST_RESP       = 3'd4;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } apb_req_t;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Flash space is 16 MiB, so the tag stops at address bit 23.
  function automatic int tag_w(input int lines);
    return 22 - $clog2(lines);
  endfunction

  function automatic logic in_flash(input logic [31:0] addr, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/xip_cache_store.sv
// Direct-mapped word store: combinational lookup, one write/invalidate port, global flush.
import xip_cache_pkg::*;

module xip_cache_store #(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_hit,
  output logic [31:0]      lk_data,
  input  logic             wr_en,
  input  logic             wr_inval,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic             flush_all
);

  logic [LINES-1:0]            valid;
  logic [LINES-1:0][TAG_W-1:0] tag_mem;
  logic [LINES-1:0][31:0]      data_mem;
  logic                        wr_tag_match;

  assign lk_hit       = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign lk_data      = data_mem[lk_idx];
  assign wr_tag_match = (tag_mem[wr_idx] == wr_tag);

  // Flush beats a same-cycle fill: the data lands but the line stays invalid.
  always_ff @(posedge clock) begin
    if (!reset)                 valid <= '0;
    else if (flush_all)         valid <= '0;
    else if (wr_en) begin
      if (!wr_inval)            valid[wr_idx] <= 1'b1;
      else if (wr_tag_match)    valid[wr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !wr_inval) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/apb_xip_cache.sv
// APB read cache in front of the SPI/XIP slave: zero-wait hits, one-for-one forwarding otherwise.
import xip_cache_pkg::*;

module apb_xip_cache #(
  parameter int          LINES            = 16,
  parameter logic [31:0] flash_addr_start = FLASH_START,
  parameter logic [31:0] flash_addr_end   = FLASH_END
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr,
  input  logic        flush,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(LINES);

  state_t      state;
  apb_req_t    req_q;
  logic        cache_q, win_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        setup, lk_win, lk_cache, lk_hit, fwd_done, wr_en;
  logic [31:0] lk_data;

  assign setup    = in_psel && !in_penable;
  assign lk_win   = in_flash(in_paddr, flash_addr_start, flash_addr_end);
  assign lk_cache = lk_win && !in_pwrite;
  assign fwd_done = (state == ST_FWD_ACCESS) && out_pready;
  // Reads fill only on a clean response; in-window writes always try to invalidate.
  assign wr_en    = fwd_done && win_q && (req_q.write || !out_pslverr);

  xip_cache_store #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_store (
    .clock     (clock),
    .reset     (reset),
    .lk_idx    (in_paddr[IDX_W+1:2]),
    .lk_tag    (in_paddr[23:IDX_W+2]),
    .lk_hit    (lk_hit),
    .lk_data   (lk_data),
    .wr_en     (wr_en),
    .wr_inval  (req_q.write),
    .wr_idx    (req_q.addr[IDX_W+1:2]),
    .wr_tag    (req_q.addr[23:IDX_W+2]),
    .wr_data   (out_prdata),
    .flush_all (flush)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      cache_q    <= 1'b0;
      win_q      <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        ST_IDLE: if (setup) begin
          req_q   <= '{addr: in_paddr, write: in_pwrite, wdata: in_pwdata,
                       strb: in_pstrb, prot: in_pprot};
          cache_q <= lk_cache;
          win_q   <= lk_win;
          // A flush in the lookup cycle forces the miss path.
          if (lk_cache && lk_hit && !flush) begin
            rdata_q <= lk_data;
            err_q   <= 1'b0;
            state   <= ST_HIT;
          end else begin
            state   <= ST_FWD_SETUP;
          end
        end
        ST_HIT: begin
          if (hit_count != '1) hit_count <= hit_count + 32'd1;
          state <= ST_IDLE;
        end
        ST_FWD_SETUP: state <= ST_FWD_ACCESS;
        ST_FWD_ACCESS: if (out_pready) begin
          rdata_q <= out_prdata;
          err_q   <= out_pslverr;
          if (cache_q && miss_count != '1) miss_count <= miss_count + 32'd1;
          state   <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_pready   = (state == ST_HIT) || (state == ST_RESP);
  assign in_prdata   = rdata_q;
  assign in_pslverr  = err_q;

  assign out_psel    = (state == ST_FWD_SETUP) || (state == ST_FWD_ACCESS);
  assign out_penable = (state == ST_FWD_ACCESS);
  assign out_paddr   = req_q.addr;
  assign out_pwrite  = req_q.write;
  assign out_pwdata  = req_q.wdata;
  assign out_pstrb   = req_q.strb;
  assign out_pprot   = req_q.prot;

endmodule
